mem_bus_responder: RTL and testbench
====================================

Name: mem_bus_responder

Overview:
- Memory-side responder for the processor control bus driven by the microcoded control sequencers.
- It accepts an address phase, then serves active-low read and write strobes from a single-port byte memory.
- It returns read data in the cycles where the sequencer latches it (LMAH, LMAL, LMD, LAC with MR low).
- It flags protocol violations so control-sequence bugs are caught at the memory boundary.

Parameters:
AW, 16, address bus width
DW, 8, data width
DEPTH_LOG2, 8, implemented memory is 2**DEPTH_LOG2 bytes at addresses 0..2**DEPTH_LOG2-1
OOR_DATA, 8'hFF, read data returned for an out-of-range address

Ports:
clock  in  1  system clock; all state changes on its rising edge
reset_n  in  1  asynchronous active-low reset
addr_en  in  1  address phase valid (OR of PC/MA/SP address enables)
addr  in  AW  address bus, sampled when addr_en=1
mr_n  in  1  read strobe, active low
mw_n  in  1  write strobe, active low
wdata  in  DW  write data, sampled with the first mw_n=0
rdata  out  DW  read data
rdata_oe  out  1  rdata valid / bus drive enable
err  out  1  sticky protocol error
err_code  out  2  first error cause: 0 short read, 1 strobe without address, 2 both strobes low, 3 out of range
err_clr  in  1  synchronous clear of err/err_code
rd_count  out  16  completed reads, wraps
wr_count  out  16  completed writes, wraps

Behaviour:
- Reset is asynchronous. While reset_n=0 and after release: state=IDLE, rdata=0, rdata_oe=0, err=0, err_code=0, rd_count=0, wr_count=0. Memory contents are not reset.
- Reset mid-transaction aborts it. No write or count update occurs.
- State IDLE:
  - addr_en=1 → latch addr into a_q; go to ADDR.
  - mr_n=0 or mw_n=0 with addr_en=0 → error code 1; stay in IDLE.
- State ADDR:
  - both strobes low → error code 2; go to IDLE.
  - mr_n=0 → go to RD. At the same edge, rdata is loaded with mem[a_q] (OOR_DATA if out of range) and rdata_oe=1.
  - mw_n=0 → perform the write at this edge: mem[a_q]=wdata if in range, else dropped with error code 3. wr_count increments in both cases. Go to WR.
  - addr_en=1, no strobe → re-latch a_q; stay in ADDR.
  - addr_en=0, no strobe → go to IDLE.
- Read latency:
  - Data is valid from the edge that samples the first mr_n=0.
  - The sequencer's second MR-low cycle therefore sees stable data.
- State RD:
  - mr_n=0 → hold rdata and rdata_oe; go to RD_HOLD.
  - mr_n=1 → short read: error code 0, rdata_oe=0; go to IDLE.
- State RD_HOLD:
  - mr_n=0 → hold data (extended reads are legal).
  - mr_n=1 → rdata_oe=0, rd_count+1; go to ADDR if addr_en=1 (re-latch a_q), else IDLE.
- State WR:
  - mw_n=0 → no further write (exactly one write per strobe).
  - mw_n=1 → go to ADDR if addr_en=1, else IDLE.
- An out-of-range read sets error code 3 and still completes and counts.
- rdata keeps its last value when rdata_oe=0.
- Error recording:
  - err is set on the first error; err_code records the cause of that first error only.
  - Later errors are ignored until err_clr.
  - If err_clr and a new error occur in the same cycle, the new error wins.
- Counters wrap from 16'hFFFF to 0.
- addr changes while in RD/RD_HOLD/WR are ignored. a_q is only updated in IDLE and ADDR and on transaction exit.

Decomposition:
- Package mem_bus_pkg holds:
  - state enum: IDLE, ADDR, RD, RD_HOLD, WR
  - err_code constants: ERR_SHORT_RD, ERR_NO_ADDR, ERR_BOTH, ERR_OOR
  - default widths
- Sub-module mem_bus_ram: single-port 2**DEPTH_LOG2 x DW array with synchronous write and synchronous (registered) read.
- The responder FSM, range check, error latch and counters live in mem_bus_responder.

Test Plan:
- Write then read:
  - Write: addr_en cycle at 16'h0010, then mw_n=0 with wdata=8'hA5 → wr_count=1.
  - Read: addr_en at 16'h0010, then mr_n=0 for 2 cycles → rdata=8'hA5 with rdata_oe=1 for exactly 2 cycles, rd_count=1, err=0.
- Out-of-range read: read of 16'h0100 with DEPTH_LOG2=8 → rdata=8'hFF, err=1, err_code=3, rd_count increments.
- Short read: addr_en then mr_n=0 for 1 cycle → err=1, err_code=0, rdata_oe low next cycle, rd_count unchanged.
- Protocol errors:
  - mr_n=0 in IDLE without addr_en → err_code=1.
  - After err_clr, both strobes low in ADDR → err_code=2.
- Write strobe length: mw_n held low for 3 cycles with wdata changing 8'h11→8'h22 → memory holds 8'h11, wr_count=1.
- Reset during RD_HOLD: reset_n pulsed low → rdata_oe=0 immediately, FSM in IDLE, counters=0; a subsequent read returns previously written data.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the control-bus memory responder.
// FSM states, error cause codes and default bus widths.
package mem_bus_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    RD      = 3'd2,
    RD_HOLD = 3'd3,
    WR      = 3'd4
  } state_t;

  localparam logic [1:0] ERR_SHORT_RD = 2'd0;
  localparam logic [1:0] ERR_NO_ADDR  = 2'd1;
  localparam logic [1:0] ERR_BOTH     = 2'd2;
  localparam logic [1:0] ERR_OOR      = 2'd3;

  localparam int AW_DEF         = 16;
  localparam int DW_DEF         = 8;
  localparam int DEPTH_LOG2_DEF = 8;

endpackage

// File: rtl/mem_bus_ram.sv
// Single-port byte RAM: write takes effect at the clock edge, read data is
// registered (one edge after the address is presented); no backpressure.
module mem_bus_ram #(
  parameter int DW         = 8,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DW-1:0]         wdata,
  output logic [DW-1:0]         rdata
);

  logic [DW-1:0] mem [0:(2**DEPTH_LOG2)-1];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder for the sequencer control bus: address phase, then
// active-low read/write strobes; read data valid from the edge sampling the first mr_n=0.
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int             AW         = AW_DEF,
  parameter int             DW         = DW_DEF,
  parameter int             DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter logic [DW-1:0]  OOR_DATA   = 8'hFF
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          addr_en,
  input  logic [AW-1:0] addr,
  input  logic          mr_n,
  input  logic          mw_n,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          rdata_oe,
  output logic          err,
  output logic [1:0]    err_code,
  input  logic          err_clr,
  output logic [15:0]   rd_count,
  output logic [15:0]   wr_count
);

  state_t        state;
  logic [AW-1:0] a_q;
  logic [AW-1:0] a_d;
  logic          in_range;
  logic          ram_we;
  logic [DW-1:0] ram_q;
  logic          new_err;
  logic [1:0]    new_code;

  assign in_range = ((a_q >> DEPTH_LOG2) == '0);
  assign ram_we   = (state == ADDR) && !mw_n && mr_n && in_range;

  // The RAM reads at a_d, so by the time ADDR is entered (or re-latched) the
  // registered read already holds mem[a_q] for a zero-wait first read edge.
  always_comb begin
    a_d = a_q;
    case (state)
      IDLE:    if (addr_en) a_d = addr;
      ADDR:    if (mr_n && mw_n && addr_en) a_d = addr;
      RD_HOLD: if (mr_n && addr_en) a_d = addr;
      WR:      if (mw_n && addr_en) a_d = addr;
      default: a_d = a_q;
    endcase
  end

  always_comb begin
    new_err  = 1'b0;
    new_code = ERR_SHORT_RD;
    case (state)
      IDLE: begin
        if (!addr_en && (!mr_n || !mw_n)) begin
          new_err  = 1'b1;
          new_code = ERR_NO_ADDR;
        end
      end
      ADDR: begin
        if (!mr_n && !mw_n) begin
          new_err  = 1'b1;
          new_code = ERR_BOTH;
        end else if ((!mr_n || !mw_n) && !in_range) begin
          new_err  = 1'b1;
          new_code = ERR_OOR;
        end
      end
      RD: begin
        if (mr_n) begin
          new_err  = 1'b1;
          new_code = ERR_SHORT_RD;
        end
      end
      default: begin
        new_err  = 1'b0;
        new_code = ERR_SHORT_RD;
      end
    endcase
  end

  mem_bus_ram #(
    .DW         (DW),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .addr  (a_d[DEPTH_LOG2-1:0]),
    .wdata (wdata),
    .rdata (ram_q)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      a_q      <= '0;
      rdata    <= '0;
      rdata_oe <= 1'b0;
      err      <= 1'b0;
      err_code <= ERR_SHORT_RD;
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      a_q <= a_d;

      case (state)
        IDLE: begin
          if (addr_en) state <= ADDR;
        end
        ADDR: begin
          if (!mr_n && !mw_n) begin
            state <= IDLE;
          end else if (!mr_n) begin
            state    <= RD;
            rdata    <= in_range ? ram_q : OOR_DATA;
            rdata_oe <= 1'b1;
          end else if (!mw_n) begin
            // Dropped out-of-range writes still count as completed.
            state    <= WR;
            wr_count <= wr_count + 16'd1;
          end else if (!addr_en) begin
            state <= IDLE;
          end
        end
        RD: begin
          if (mr_n) begin
            state    <= IDLE;
            rdata_oe <= 1'b0;
          end else begin
            state <= RD_HOLD;
          end
        end
        RD_HOLD: begin
          if (mr_n) begin
            rdata_oe <= 1'b0;
            rd_count <= rd_count + 16'd1;
            state    <= addr_en ? ADDR : IDLE;
          end
        end
        WR: begin
          if (mw_n) state <= addr_en ? ADDR : IDLE;
        end
        default: state <= IDLE;
      endcase

      // First error is sticky; a new error in the clearing cycle takes over.
      if (new_err && (!err || err_clr)) begin
        err      <= 1'b1;
        err_code <= new_code;
      end else if (err_clr) begin
        err      <= 1'b0;
        err_code <= ERR_SHORT_RD;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Scoreboard bench for mem_bus_responder: expected read data queued at issue,
// popped when the read completes; counters and errors checked per scenario.
module tb_mem_bus_responder;

  logic        clock;
  logic        reset_n;
  logic        addr_en;
  logic [15:0] addr;
  logic        mr_n;
  logic        mw_n;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        rdata_oe;
  logic        err;
  logic [1:0]  err_code;
  logic        err_clr;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  int errors = 0;
  int checks = 0;

  logic [7:0]  model [0:255];
  logic [7:0]  exp_q [$];
  logic [15:0] exp_rd = 16'd0;
  logic [15:0] exp_wr = 16'd0;

  mem_bus_responder dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .addr_en  (addr_en),
    .addr     (addr),
    .mr_n     (mr_n),
    .mw_n     (mw_n),
    .wdata    (wdata),
    .rdata    (rdata),
    .rdata_oe (rdata_oe),
    .err      (err),
    .err_code (err_code),
    .err_clr  (err_clr),
    .rd_count (rd_count),
    .wr_count (wr_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d0,
                          input logic [7:0] d1, input int n);
    addr_en = 1'b1;
    addr    = a;
    tick();
    addr_en = 1'b0;
    addr    = 16'hBEEF;
    mw_n    = 1'b0;
    wdata   = d0;
    tick();
    wdata = d1;
    for (int i = 1; i < n; i++) tick();
    mw_n = 1'b1;
    tick();
    if (a < 16'd256) model[a[7:0]] = d0;
    exp_wr = exp_wr + 16'd1;
  endtask

  task automatic do_read(input logic [15:0] a, input int n, output logic [7:0] last,
                         output int oe_cnt, output logic oe_after);
    exp_q.push_back((a < 16'd256) ? model[a[7:0]] : 8'hFF);
    addr_en = 1'b1;
    addr    = a;
    tick();
    addr_en = 1'b0;
    addr    = 16'hDEAD;
    mr_n    = 1'b0;
    oe_cnt  = 0;
    last    = 8'hxx;
    for (int i = 0; i < n; i++) begin
      tick();
      if (rdata_oe === 1'b1) begin
        oe_cnt++;
        last = rdata;
      end
    end
    mr_n = 1'b1;
    tick();
    oe_after = rdata_oe;
    if (n >= 2) exp_rd = exp_rd + 16'd1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (rdata_oe !== 1'b0) begin errors++; $display("FAIL reset_oe_low: got %b want 0", rdata_oe); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h want 00", rdata); end
    reset_n = 1'b1;
    tick();
    checks++; if (err !== 1'b0 || err_code !== 2'd0) begin errors++; $display("FAIL reset_err: got %b/%0d want 0/0", err, err_code); end
    checks++; if (rd_count !== 16'd0 || wr_count !== 16'd0) begin errors++; $display("FAIL reset_counts: got rd=%0d wr=%0d want 0/0", rd_count, wr_count); end
  endtask

  task automatic test_write_read();
    logic [7:0] last, exp;
    int oe_cnt;
    logic oe_after;
    do_write(16'h0010, 8'hA5, 8'hA5, 1);
    checks++; if (wr_count !== exp_wr) begin errors++; $display("FAIL wr_count_after_write: got %0d want %0d", wr_count, exp_wr); end
    do_read(16'h0010, 2, last, oe_cnt, oe_after);
    exp = exp_q.pop_front();
    checks++; if (last !== exp) begin errors++; $display("FAIL read_data: got %h want %h", last, exp); end
    checks++; if (oe_cnt !== 2 || oe_after !== 1'b0) begin errors++; $display("FAIL read_oe_window: got %0d cycles/after=%b want 2/0", oe_cnt, oe_after); end
    checks++; if (rdata !== 8'hA5) begin errors++; $display("FAIL rdata_hold: got %h want a5", rdata); end
    checks++; if (rd_count !== exp_rd || err !== 1'b0) begin errors++; $display("FAIL read_count_err: got rd=%0d err=%b want %0d/0", rd_count, err, exp_rd); end
  endtask

  task automatic test_oor_read();
    logic [7:0] last, exp;
    int oe_cnt;
    logic oe_after;
    do_read(16'h0100, 2, last, oe_cnt, oe_after);
    exp = exp_q.pop_front();
    checks++; if (last !== exp) begin errors++; $display("FAIL oor_data: got %h want %h", last, exp); end
    checks++; if (err !== 1'b1 || err_code !== 2'd3) begin errors++; $display("FAIL oor_err: got %b/%0d want 1/3", err, err_code); end
    checks++; if (rd_count !== exp_rd) begin errors++; $display("FAIL oor_count: got %0d want %0d", rd_count, exp_rd); end
    clear_err();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clr: got %b want 0", err); end
  endtask

  task automatic test_short_read();
    logic [7:0] last, exp;
    int oe_cnt;
    logic oe_after;
    do_read(16'h0010, 1, last, oe_cnt, oe_after);
    exp = exp_q.pop_front();
    checks++; if (last !== exp || oe_cnt !== 1) begin errors++; $display("FAIL short_data: got %h/%0d want %h/1", last, oe_cnt, exp); end
    checks++; if (oe_after !== 1'b0) begin errors++; $display("FAIL short_oe_drop: got %b want 0", oe_after); end
    checks++; if (err !== 1'b1 || err_code !== 2'd0) begin errors++; $display("FAIL short_err: got %b/%0d want 1/0", err, err_code); end
    checks++; if (rd_count !== exp_rd) begin errors++; $display("FAIL short_count: got %0d want %0d", rd_count, exp_rd); end
    clear_err();
  endtask

  task automatic test_protocol();
    mr_n = 1'b0;
    tick();
    mr_n = 1'b1;
    checks++; if (err !== 1'b1 || err_code !== 2'd1) begin errors++; $display("FAIL no_addr_err: got %b/%0d want 1/1", err, err_code); end
    clear_err();
    addr_en = 1'b1; addr = 16'h0040;
    tick();
    addr_en = 1'b0; mr_n = 1'b0; mw_n = 1'b0;
    tick();
    mr_n = 1'b1; mw_n = 1'b1;
    checks++; if (err !== 1'b1 || err_code !== 2'd2) begin errors++; $display("FAIL both_err: got %b/%0d want 1/2", err, err_code); end
    checks++; if (rdata_oe !== 1'b0 || wr_count !== exp_wr) begin errors++; $display("FAIL both_no_txn: got oe=%b wr=%0d want 0/%0d", rdata_oe, wr_count, exp_wr); end
    mw_n = 1'b0;
    tick();
    mw_n = 1'b1;
    checks++; if (err_code !== 2'd2) begin errors++; $display("FAIL first_err_kept: got %0d want 2", err_code); end
    err_clr = 1'b1; mr_n = 1'b0;
    tick();
    err_clr = 1'b0; mr_n = 1'b1;
    checks++; if (err !== 1'b1 || err_code !== 2'd1) begin errors++; $display("FAIL clr_vs_new: got %b/%0d want 1/1", err, err_code); end
    clear_err();
  endtask

  task automatic test_write_strobe();
    logic [7:0] last, exp;
    int oe_cnt;
    logic oe_after;
    do_write(16'h0020, 8'h11, 8'h22, 3);
    checks++; if (wr_count !== exp_wr) begin errors++; $display("FAIL strobe_wr_count: got %0d want %0d", wr_count, exp_wr); end
    do_read(16'h0020, 2, last, oe_cnt, oe_after);
    exp = exp_q.pop_front();
    checks++; if (last !== exp) begin errors++; $display("FAIL strobe_data: got %h want %h", last, exp); end
    do_write(16'h0200, 8'h77, 8'h77, 1);
    checks++; if (err !== 1'b1 || err_code !== 2'd3 || wr_count !== exp_wr) begin errors++; $display("FAIL oor_write: got %b/%0d wr=%0d want 1/3/%0d", err, err_code, wr_count, exp_wr); end
    clear_err();
  endtask

  task automatic test_back_to_back();
    logic [7:0] last, exp;
    int oe_cnt;
    logic oe_after;
    logic [15:0] a;
    for (int i = 0; i < 8; i++) begin
      a = 16'(8'h80 + 8'($urandom_range(0, 127)));
      do_write(a, 8'($urandom), 8'h00, 1);
      do_read(a, 2 + (i % 3), last, oe_cnt, oe_after);
      exp = exp_q.pop_front();
      checks++; if (last !== exp || oe_cnt !== 2 + (i % 3)) begin errors++; $display("FAIL b2b_read_%0d: got %h/%0d want %h/%0d", i, last, oe_cnt, exp, 2 + (i % 3)); end
    end
    checks++; if (rd_count !== exp_rd || wr_count !== exp_wr || err !== 1'b0) begin errors++; $display("FAIL b2b_counts: got rd=%0d wr=%0d err=%b want %0d/%0d/0", rd_count, wr_count, err, exp_rd, exp_wr); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] last, exp;
    int oe_cnt;
    logic oe_after;
    do_write(16'h0030, 8'h5A, 8'h5A, 1);
    addr_en = 1'b1; addr = 16'h0030;
    tick();
    addr_en = 1'b0; mr_n = 1'b0;
    tick();
    tick();
    checks++; if (rdata_oe !== 1'b1) begin errors++; $display("FAIL mid_oe_before_reset: got %b want 1", rdata_oe); end
    reset_n = 1'b0;
    #1;
    checks++; if (rdata_oe !== 1'b0 || rd_count !== 16'd0 || wr_count !== 16'd0) begin errors++; $display("FAIL mid_reset_async: got oe=%b rd=%0d wr=%0d want 0/0/0", rdata_oe, rd_count, wr_count); end
    mr_n = 1'b1;
    tick();
    reset_n = 1'b1;
    exp_rd = 16'd0;
    exp_wr = 16'd0;
    tick();
    do_read(16'h0030, 2, last, oe_cnt, oe_after);
    exp = exp_q.pop_front();
    checks++; if (last !== exp) begin errors++; $display("FAIL post_reset_data: got %h want %h", last, exp); end
    checks++; if (rd_count !== exp_rd) begin errors++; $display("FAIL post_reset_count: got %0d want %0d", rd_count, exp_rd); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
    reset_n = 1'b0;
    addr_en = 1'b0;
    addr    = 16'h0000;
    mr_n    = 1'b1;
    mw_n    = 1'b1;
    wdata   = 8'h00;
    err_clr = 1'b0;
    test_reset();
    test_write_read();
    test_oor_read();
    test_short_read();
    test_protocol();
    test_write_strobe();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
